kitchen_timer_ctrl: RTL and testbench



---
 rtl/kitchen_timer_ctrl_pkg.sv | 14 +
 rtl/kitchen_timer_ctrl_if.sv | 16 +
 rtl/kitchen_timer_ctrl_btn_edge_repeat.sv | 36 +++
 rtl/kitchen_timer_ctrl.sv | 102 ++++++++++
 tb/tb_kitchen_timer_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/kitchen_timer_ctrl_pkg.sv
// kitchen_timer_pkg: state codes and LED patterns shared by the kitchen timer controller
package kitchen_timer_pkg;
  localparam int ST_W = 3;
  localparam int LED_W = 10;
  typedef enum logic [ST_W-1:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    ALARM = 3'd4
  } state_t;
  localparam logic [LED_W-1:0] LED_SET = 10'h200;
  localparam logic [LED_W-1:0] LED_PAUSE = 10'h001;
endpackage

// File: rtl/kitchen_timer_ctrl_if.sv
// kitchen_timer_ctrl_if: button/tick inputs and command/status outputs of the timer controller
interface kitchen_timer_ctrl_if;
  import kitchen_timer_pkg::*;
  logic tick_ms, btn_ss, btn_min, btn_sec, set_mode, clear, cnt_zero;
  logic dec_en, inc_min, inc_sec, cnt_clr, running, alarm;
  logic [LED_W-1:0] led;
  logic [ST_W-1:0] state;
  modport master (
    output tick_ms, btn_ss, btn_min, btn_sec, set_mode, clear, cnt_zero,
    input dec_en, inc_min, inc_sec, cnt_clr, running, alarm, led, state
  );
  modport slave (
    input tick_ms, btn_ss, btn_min, btn_sec, set_mode, clear, cnt_zero,
    output dec_en, inc_min, inc_sec, cnt_clr, running, alarm, led, state
  );
endinterface

// File: rtl/kitchen_timer_ctrl_btn_edge_repeat.sv
// btn_edge_repeat: rising-edge detector with hold-to-repeat when KTCTRL_AUTOREPEAT_EN is defined
module btn_edge_repeat #(
  parameter int REPEAT_DLY_MS = 500,
  parameter int REPEAT_MS = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic lvl,
  input  logic rep_en,
  output logic hit
);
  logic prev;
  // prev follows the level in reset too, so a button held through reset yields no edge
  always_ff @(posedge clk) prev <= lvl;
`ifdef KTCTRL_AUTOREPEAT_EN
  localparam int CW = $clog2(REPEAT_DLY_MS > REPEAT_MS ? REPEAT_DLY_MS : REPEAT_MS);
  logic [CW-1:0] cnt;
  logic rep, fire;
  assign fire = rep_en && lvl && tick && (cnt == CW'(rep ? REPEAT_MS - 1 : REPEAT_DLY_MS - 1));
  always_ff @(posedge clk) begin
    if (!rst_n || !rep_en || !lvl) begin
      cnt <= '0;
      rep <= 1'b0;
    end else if (tick) begin
      cnt <= fire ? '0 : cnt + 1'b1;
      rep <= rep | fire;
    end
  end
  assign hit = (lvl && !prev) || fire;
`else
  logic unused_ok;
  assign unused_ok = ^{rst_n, tick, rep_en} ^ (REPEAT_DLY_MS > REPEAT_MS);
  assign hit = lvl && !prev;
`endif
endmodule

// File: rtl/kitchen_timer_ctrl.sv
// kitchen_timer_ctrl: run/pause/alarm sequencer with 1 s prescaler and button handling for the MM:SS timer
// Define KTCTRL_AUTOREPEAT_EN for hold-to-repeat on the minute/second set buttons.
module kitchen_timer_ctrl
  import kitchen_timer_pkg::*;
#(
  parameter int MS_PER_SEC = 1000,
  parameter int ALARM_SECS = 10,
  parameter int BLINK_MS = 250,
  parameter int REPEAT_DLY_MS = 500,
  parameter int REPEAT_MS = 100
) (
  input logic clk,
  input logic rst_n,
  kitchen_timer_ctrl_if.slave bus
);
  localparam int ALARM_MS = ALARM_SECS * 1000;
  localparam int PW = $clog2(MS_PER_SEC);
  localparam int AW = $clog2(ALARM_MS);
  localparam int BW = $clog2(BLINK_MS);
  state_t st;
  logic [PW-1:0] pre;
  logic [AW-1:0] alm;
  logic [BW-1:0] blk;
  logic run_led, blink, dec_en, inc_min, inc_sec, cnt_clr;
  logic e_ss, e_min, e_sec, e_clr, pre_exp, alm_exp, blk_exp, in_set;
  assign in_set = st == SET;
  btn_edge_repeat #(.REPEAT_DLY_MS(REPEAT_DLY_MS), .REPEAT_MS(REPEAT_MS)) u_ss (
    .clk(clk), .rst_n(rst_n), .tick(bus.tick_ms), .lvl(bus.btn_ss), .rep_en(1'b0), .hit(e_ss));
  btn_edge_repeat #(.REPEAT_DLY_MS(REPEAT_DLY_MS), .REPEAT_MS(REPEAT_MS)) u_clr (
    .clk(clk), .rst_n(rst_n), .tick(bus.tick_ms), .lvl(bus.clear), .rep_en(1'b0), .hit(e_clr));
  btn_edge_repeat #(.REPEAT_DLY_MS(REPEAT_DLY_MS), .REPEAT_MS(REPEAT_MS)) u_min (
    .clk(clk), .rst_n(rst_n), .tick(bus.tick_ms), .lvl(bus.btn_min), .rep_en(in_set), .hit(e_min));
  btn_edge_repeat #(.REPEAT_DLY_MS(REPEAT_DLY_MS), .REPEAT_MS(REPEAT_MS)) u_sec (
    .clk(clk), .rst_n(rst_n), .tick(bus.tick_ms), .lvl(bus.btn_sec), .rep_en(in_set), .hit(e_sec));
  assign pre_exp = bus.tick_ms && pre == PW'(MS_PER_SEC - 1);
  assign alm_exp = bus.tick_ms && alm == AW'(ALARM_MS - 1);
  assign blk_exp = bus.tick_ms && blk == BW'(BLINK_MS - 1);
  always_ff @(posedge clk) begin
    dec_en <= 1'b0;
    inc_min <= 1'b0;
    inc_sec <= 1'b0;
    cnt_clr <= 1'b0;
    if (!rst_n) begin
      st <= IDLE;
      pre <= '0;
      alm <= '0;
      blk <= '0;
      run_led <= 1'b0;
      blink <= 1'b0;
    end else if (e_clr) begin
      cnt_clr <= 1'b1;
      st <= bus.set_mode ? SET : IDLE;
      pre <= '0;
    end else if (bus.set_mode && st != SET) begin
      st <= SET;
      pre <= '0;
    end else begin
      case (st)
        IDLE: if (e_ss && !bus.cnt_zero) begin
          st <= RUN;
          pre <= '0;
        end
        SET: begin
          inc_min <= e_min;
          inc_sec <= e_sec;
          if (!bus.set_mode) st <= IDLE;
        end
        // pausing on an expiry cycle drops that decrement and keeps the fraction
        RUN: if (bus.cnt_zero) begin
          st <= ALARM;
          alm <= '0;
          blk <= '0;
          blink <= 1'b1;
        end else if (e_ss) st <= PAUSE;
        else if (bus.tick_ms) begin
          pre <= pre_exp ? '0 : pre + 1'b1;
          dec_en <= pre_exp;
          run_led <= run_led ^ pre_exp;
        end
        PAUSE: if (e_ss) st <= bus.cnt_zero ? IDLE : RUN;
        ALARM: if (e_ss || e_min || e_sec || alm_exp) st <= IDLE;
        else if (bus.tick_ms) begin
          alm <= alm + 1'b1;
          blk <= blk_exp ? '0 : blk + 1'b1;
          blink <= blink ^ blk_exp;
        end
        default: st <= IDLE;
      endcase
    end
  end
  assign bus.dec_en = dec_en;
  assign bus.inc_min = inc_min;
  assign bus.inc_sec = inc_sec;
  assign bus.cnt_clr = cnt_clr;
  assign bus.state = st;
  assign bus.running = st == RUN;
  assign bus.alarm = st == ALARM;
  assign bus.led = st == SET ? LED_SET :
                   st == PAUSE ? LED_PAUSE :
                   st == RUN ? {{(LED_W-1){1'b0}}, run_led} :
                   st == ALARM ? {LED_W{blink}} : '0;
endmodule

// File: tb/tb_kitchen_timer_ctrl.sv
// tb_kitchen_timer_ctrl: randomized scoreboard bench for kitchen_timer_ctrl
module tb_kitchen_timer_ctrl;
  import kitchen_timer_pkg::*;
  localparam int MS = 1000, ASEC = 10, BLINK = 250, RDLY = 500, RMS = 100;
  localparam int K_ST = 0, K_LED = 1, K_DEC = 2, K_MIN = 3, K_SEC = 4, K_CLR = 5;
  localparam int P_SS = 0, P_MIN = 1, P_SEC = 2, P_BOTH = 3, P_CLR = 4;
  typedef struct {int kind; int cyc; int val;} ev_t;
  ev_t exp_q[$];
  logic clk = 0, rst_n = 0;
  int cyc = 0, checks = 0, failures = 0;
  bit mon_en = 0;
  int m_state = 0, m_led = 0, m_frac = 0, m_led0 = 0, m_blink = 0, m_alm = 0, m_hold = -1;
  int p_state = 0, p_led = 0;
  kitchen_timer_ctrl_if bus();
  kitchen_timer_ctrl #(.MS_PER_SEC(MS), .ALARM_SECS(ASEC), .BLINK_MS(BLINK),
    .REPEAT_DLY_MS(RDLY), .REPEAT_MS(RMS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic void expect_ev(int k, int c, int v);
    ev_t e;
    e.kind = k;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
  endfunction
  function automatic int led_now();
    case (m_state)
      1: return 'h200;
      2: return m_led0;
      3: return 1;
      4: return m_blink ? 'h3ff : 0;
      default: return 0;
    endcase
  endfunction
  function automatic void go(int c, int s);
    if (s != m_state) expect_ev(K_ST, c, s);
    m_state = s;
    if (led_now() != m_led) begin
      m_led = led_now();
      expect_ev(K_LED, c, m_led);
    end
  endfunction
  function automatic void model_tick(int c);
    if (m_state == 2) begin
      m_frac++;
      if (m_frac == MS) begin
        m_frac = 0;
        m_led0 = 1 - m_led0;
        expect_ev(K_DEC, c, 1);
        go(c, 2);
      end
    end else if (m_state == 4) begin
      m_alm++;
      if (m_alm == ASEC * 1000) go(c, 0);
      else if (m_alm % BLINK == 0) begin
        m_blink = 1 - m_blink;
        go(c, 4);
      end
    end else if (m_state == 1 && m_hold >= 0) begin
      m_hold++;
`ifdef KTCTRL_AUTOREPEAT_EN
      if (m_hold >= RDLY && (m_hold - RDLY) % RMS == 0) expect_ev(K_SEC, c, 1);
`endif
    end
  endfunction
  task automatic chk(string nm, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", nm, got, want);
    end
  endtask
  task automatic observe(int k, int v, string nm);
    int idx[$];
    ev_t e;
    checks++;
    idx = exp_q.find_first_index(item) with (item.kind == k);
    if (idx.size() == 0) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d, required no event", nm, cyc, v);
    end else begin
      e = exp_q[idx[0]];
      exp_q.delete(idx[0]);
      if (e.cyc != cyc || e.val != v) begin
        failures++;
        $display("FAIL %s: got %0d at cycle %0d, required %0d at cycle %0d", nm, v, cyc, e.val, e.cyc);
      end
    end
  endtask
  always @(posedge clk) begin
    cyc++;
    #1;
    if (mon_en) begin
      if (int'(bus.state) != p_state) begin
        observe(K_ST, int'(bus.state), "state");
        chk("running", int'(bus.running), int'(m_state == 2));
        chk("alarm", int'(bus.alarm), int'(m_state == 4));
        p_state = int'(bus.state);
      end
      if (int'(bus.led) != p_led) begin
        observe(K_LED, int'(bus.led), "led");
        p_led = int'(bus.led);
      end
      if (bus.dec_en) observe(K_DEC, 1, "dec_en");
      if (bus.inc_min) observe(K_MIN, 1, "inc_min");
      if (bus.inc_sec) observe(K_SEC, 1, "inc_sec");
      if (bus.cnt_clr) observe(K_CLR, 1, "cnt_clr");
    end
  end
  task automatic tick_run(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.tick_ms = 1;
      model_tick(cyc + 1);
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        bus.tick_ms = 0;
      end
    end
    @(negedge clk);
    bus.tick_ms = 0;
  endtask
  task automatic press(int which);
    int c;
    @(negedge clk);
    c = cyc + 1;
    bus.btn_ss = which == P_SS;
    bus.btn_min = which == P_MIN || which == P_BOTH;
    bus.btn_sec = which == P_SEC || which == P_BOTH;
    bus.clear = which == P_CLR;
    if (which == P_CLR) begin
      expect_ev(K_CLR, c, 1);
      m_frac = 0;
      go(c, bus.set_mode ? 1 : 0);
    end else if (which == P_SS) begin
      if (m_state == 0 && !bus.cnt_zero) begin
        m_frac = 0;
        go(c, 2);
      end else if (m_state == 2) go(c, 3);
      else if (m_state == 3) go(c, bus.cnt_zero ? 0 : 2);
      else if (m_state == 4) go(c, 0);
    end else if (m_state == 1) begin
      if (bus.btn_min) expect_ev(K_MIN, c, 1);
      if (bus.btn_sec) expect_ev(K_SEC, c, 1);
    end else if (m_state == 4) go(c, 0);
    @(negedge clk);
    bus.btn_ss = 0;
    bus.btn_min = 0;
    bus.btn_sec = 0;
    bus.clear = 0;
  endtask
  task automatic set_sm(bit v);
    @(negedge clk);
    bus.set_mode = v;
    if (v && m_state != 1) go(cyc + 1, 1);
    if (!v && m_state == 1) go(cyc + 1, 0);
  endtask
  task automatic set_cz(bit v);
    @(negedge clk);
    bus.cnt_zero = v;
    if (v && m_state == 2) begin
      m_alm = 0;
      m_blink = 1;
      go(cyc + 1, 4);
    end
  endtask
  task automatic hold_sec(int n);
    @(negedge clk);
    bus.btn_sec = 1;
    expect_ev(K_SEC, cyc + 1, 1);
    m_hold = 0;
    tick_run(n);
    @(negedge clk);
    bus.btn_sec = 0;
    m_hold = -1;
  endtask
  initial begin
    bus.tick_ms = 0;
    bus.btn_ss = 1;
    bus.btn_min = 0;
    bus.btn_sec = 0;
    bus.set_mode = 0;
    bus.clear = 0;
    bus.cnt_zero = 0;
    repeat (3) @(negedge clk);
    chk("reset state", int'(bus.state), 0);
    chk("reset led", int'(bus.led), 0);
    chk("reset running", int'(bus.running), 0);
    chk("reset alarm", int'(bus.alarm), 0);
    chk("reset pulses", int'({bus.dec_en, bus.inc_min, bus.inc_sec, bus.cnt_clr}), 0);
    rst_n = 1;
    mon_en = 1;
    repeat (5) @(negedge clk);
    bus.btn_ss = 0;
    @(negedge clk);
    press(P_SS);
    tick_run(3000);
    tick_run(600);
    press(P_SS);
    tick_run(5000);
    press(P_SS);
    tick_run(400);
    tick_run($urandom_range(1, 1500));
    set_cz(1);
    tick_run(ASEC * 1000 + $urandom_range(0, 300));
    press(P_SS);
    set_cz(0);
    press(P_SS);
    tick_run($urandom_range(200, 2500));
    set_cz(1);
    tick_run($urandom_range(100, 2000));
    press(P_MIN);
    set_cz(0);
    press(P_SS);
    tick_run($urandom_range(50, 1500));
    press(P_SS);
    set_cz(1);
    press(P_SS);
    set_cz(0);
    press(P_SS);
    tick_run($urandom_range(50, 1500));
    set_sm(1);
    repeat ($urandom_range(2, 6)) press($urandom_range(P_MIN, P_BOTH));
    press(P_BOTH);
    press(P_CLR);
    hold_sec(1000);
    set_sm(0);
    press(P_SS);
    tick_run($urandom_range(50, 1500));
    press(P_CLR);
    press(P_CLR);
    repeat (20) @(negedge clk);
    foreach (exp_q[i]) begin
      checks++;
      failures++;
      $display("FAIL missing event kind=%0d: got nothing, required %0d at cycle %0d", exp_q[i].kind, exp_q[i].val, exp_q[i].cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
